// File: rtl/nor_gate.sv
// -----------------------------------------------------------------------------
// nor_gate
//
// Registered bitwise NOR of two WIDTH-bit operands with registered status
// flags. Every rising clk edge with rst low samples new operands; the result
// and its flags appear together exactly one clock later and hold until the
// next edge.
//
// Optional feature macro: NOR_GATE_STATS_EN
//   When defined, adds two 16-bit wrapping counters (op_count, zero_count).
//   When undefined, those ports and their logic are absent.
//
// Ports
//   clk        in   1      rising-edge clock
//   rst        in   1      synchronous, active-high reset
//   in1        in   WIDTH  first operand
//   in2        in   WIDTH  second operand
//   out        out  WIDTH  registered ~(in1 | in2)
//   out_valid  out  1      out holds a result computed since reset
//   zero       out  1      out is all zeros
//   all_ones   out  1      out is all ones
//   parity     out  1      XOR-reduction of out
//   op_count   out  16     results produced since reset (stats build only)
//   zero_count out  16     all-zero results since reset (stats build only)
// -----------------------------------------------------------------------------
module nor_gate #(
   parameter int WIDTH = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] in1,
   input  logic [WIDTH-1:0] in2,
   output logic [WIDTH-1:0] out,
   output logic             out_valid,
   output logic             zero,
   output logic             all_ones,
   output logic             parity
`ifdef NOR_GATE_STATS_EN
   ,
   output logic [15:0]      op_count,
   output logic [15:0]      zero_count
`endif
);

   // Even/odd parity of a result word (1 when an odd number of bits are set).
   function automatic logic calc_parity(input logic [WIDTH-1:0] value);
      return ^value;
   endfunction

   logic [WIDTH-1:0] out_d,      out_q;
   logic             valid_d,    valid_q;
   logic             zero_d,     zero_q;
   logic             all_ones_d, all_ones_q;
   logic             parity_d,   parity_q;

   // Next result and its flags, all derived from the same sampled operands so
   // the flags can never lag the data. X/Z bits propagate through the NOR.
   always_comb begin
      out_d      = ~(in1 | in2);
      valid_d    = 1'b1;
      zero_d     = ~(|out_d);
      all_ones_d = &out_d;
      parity_d   = calc_parity(out_d);
   end

   // Result and flag registers; reset wins over a simultaneous capture.
   always_ff @(posedge clk) begin
      if (rst) begin
         out_q      <= '0;
         valid_q    <= 1'b0;
         zero_q     <= 1'b0;
         all_ones_q <= 1'b0;
         parity_q   <= 1'b0;
      end else begin
         out_q      <= out_d;
         valid_q    <= valid_d;
         zero_q     <= zero_d;
         all_ones_q <= all_ones_d;
         parity_q   <= parity_d;
      end
   end

   assign out       = out_q;
   assign out_valid = valid_q;
   assign zero      = zero_q;
   assign all_ones  = all_ones_q;
   assign parity    = parity_q;

`ifdef NOR_GATE_STATS_EN
   logic [15:0] op_cnt_d,   op_cnt_q;
   logic [15:0] zero_cnt_d, zero_cnt_q;

   // Counter next-state; both wrap naturally at 16 bits. An unknown zero flag
   // (X operands) is not counted so the counter itself stays known.
   always_comb begin
      op_cnt_d = op_cnt_q + 16'd1;
      if (zero_d == 1'b1) begin
         zero_cnt_d = zero_cnt_q + 16'd1;
      end else begin
         zero_cnt_d = zero_cnt_q;
      end
   end

   // Statistics counter registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         op_cnt_q   <= 16'd0;
         zero_cnt_q <= 16'd0;
      end else begin
         op_cnt_q   <= op_cnt_d;
         zero_cnt_q <= zero_cnt_d;
      end
   end

   assign op_count   = op_cnt_q;
   assign zero_count = zero_cnt_q;
`endif

endmodule

// File: tb/tb_nor_gate.sv
// -----------------------------------------------------------------------------
// tb_nor_gate
//
// Directed self-checking bench for nor_gate (WIDTH = 16). Inputs are driven
// and outputs sampled on the falling clock edge. Stats checks are compiled in
// only when NOR_GATE_STATS_EN is defined.
// -----------------------------------------------------------------------------
module tb_nor_gate;

   logic        clk;
   logic        rst;
   logic [15:0] in1;
   logic [15:0] in2;
   logic [15:0] out;
   logic        out_valid;
   logic        zero;
   logic        all_ones;
   logic        parity;
`ifdef NOR_GATE_STATS_EN
   logic [15:0] op_count;
   logic [15:0] zero_count;
`endif

   int tests_run;
   int tests_failed;

   nor_gate #(.WIDTH(16)) dut (
      .clk       (clk),
      .rst       (rst),
      .in1       (in1),
      .in2       (in2),
      .out       (out),
      .out_valid (out_valid),
      .zero      (zero),
      .all_ones  (all_ones),
      .parity    (parity)
`ifdef NOR_GATE_STATS_EN
      ,
      .op_count  (op_count),
      .zero_count(zero_count)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // One active edge, then return to the sampling point.
   task automatic tick();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic test_reset();
      rst = 1'b1;
      in1 = 16'hFFFF;
      in2 = 16'h0000;
      tick();
      tick();
      tests_run++;
      if (out !== 16'h0000) begin
         tests_failed++;
         $display("FAIL reset_out got=%h exp=%h", out, 16'h0000);
      end
      tests_run++;
      if (out_valid !== 1'b0) begin
         tests_failed++;
         $display("FAIL reset_valid got=%b exp=%b", out_valid, 1'b0);
      end
      tests_run++;
      if ({zero, all_ones, parity} !== 3'b000) begin
         tests_failed++;
         $display("FAIL reset_flags got=%b exp=%b", {zero, all_ones, parity}, 3'b000);
      end
   endtask

   task automatic test_all_zero_operands();
      rst = 1'b0;
      in1 = 16'h0000;
      in2 = 16'h0000;
      tick();
      tests_run++;
      if (out !== 16'hFFFF) begin
         tests_failed++;
         $display("FAIL zeros_out got=%h exp=%h", out, 16'hFFFF);
      end
      tests_run++;
      if ({out_valid, zero, all_ones, parity} !== 4'b1010) begin
         tests_failed++;
         $display("FAIL zeros_flags got=%b exp=%b", {out_valid, zero, all_ones, parity}, 4'b1010);
      end
   endtask

   task automatic test_patterns();
      // 0x00FF | 0x0F00 = 0x0FFF -> 0xF000 (4 ones, even)
      in1 = 16'h00FF;
      in2 = 16'h0F00;
      tick();
      tests_run++;
      if ({out, zero, all_ones, parity} !== {16'hF000, 3'b000}) begin
         tests_failed++;
         $display("FAIL pat1 got=%h/%b exp=%h/%b", out, {zero, all_ones, parity}, 16'hF000, 3'b000);
      end
      // 0x1234 | 0x0001 = 0x1235 -> 0xEDCA (10 ones, even)
      in1 = 16'h1234;
      in2 = 16'h0001;
      tick();
      tests_run++;
      if ({out, zero, all_ones, parity} !== {16'hEDCA, 3'b000}) begin
         tests_failed++;
         $display("FAIL pat2 got=%h/%b exp=%h/%b", out, {zero, all_ones, parity}, 16'hEDCA, 3'b000);
      end
      // 0x8000 | 0x0000 -> 0x7FFF (15 ones, odd)
      in1 = 16'h8000;
      in2 = 16'h0000;
      tick();
      tests_run++;
      if ({out, zero, all_ones, parity} !== {16'h7FFF, 3'b001}) begin
         tests_failed++;
         $display("FAIL pat3 got=%h/%b exp=%h/%b", out, {zero, all_ones, parity}, 16'h7FFF, 3'b001);
      end
      // complementary operands cover every bit -> 0x0000
      in1 = 16'hAAAA;
      in2 = 16'h5555;
      tick();
      tests_run++;
      if ({out, zero, all_ones, parity, out_valid} !== {16'h0000, 4'b1001}) begin
         tests_failed++;
         $display("FAIL pat4 got=%h/%b exp=%h/%b", out, {zero, all_ones, parity, out_valid}, 16'h0000, 4'b1001);
      end
   endtask

   task automatic test_hold();
      in1 = 16'hFFFF;
      in2 = 16'h1234;
      tick();
      tests_run++;
      if ({out, zero} !== {16'h0000, 1'b1}) begin
         tests_failed++;
         $display("FAIL ones_operand got=%h/%b exp=%h/%b", out, zero, 16'h0000, 1'b1);
      end
      // change operands mid-cycle; output must not move before the edge
      in1 = 16'h0000;
      in2 = 16'h0000;
      #3;
      tests_run++;
      if ({out, zero, all_ones} !== {16'h0000, 2'b10}) begin
         tests_failed++;
         $display("FAIL hold got=%h/%b exp=%h/%b", out, {zero, all_ones}, 16'h0000, 2'b10);
      end
      @(negedge clk);
      tests_run++;
      if ({out, all_ones} !== {16'hFFFF, 1'b1}) begin
         tests_failed++;
         $display("FAIL after_hold got=%h/%b exp=%h/%b", out, all_ones, 16'hFFFF, 1'b1);
      end
   endtask

   task automatic test_random();
      logic [15:0] a;
      logic [15:0] b;
      logic [15:0] exp_out;
      int          zero_results;
      zero_results = 0;
      rst = 1'b1;
      tick();
      rst = 1'b0;
      for (int i = 0; i < 20; i++) begin
         a = 16'($urandom);
         b = 16'($urandom);
         if ((i % 5) == 0) begin
            a = 16'hFFFF;
         end
         in1 = a;
         in2 = b;
         exp_out = ~(a | b);
         if (exp_out == 16'h0000) begin
            zero_results++;
         end
         tick();
         tests_run++;
         if ({out, zero, all_ones, parity, out_valid} !==
             {exp_out, (exp_out == 16'h0000), (exp_out == 16'hFFFF), ^exp_out, 1'b1}) begin
            tests_failed++;
            $display("FAIL random[%0d] got=%h/%b exp=%h a=%h b=%h", i, out,
                     {zero, all_ones, parity, out_valid}, exp_out, a, b);
         end
      end
`ifdef NOR_GATE_STATS_EN
      tests_run++;
      if (op_count !== 16'd20) begin
         tests_failed++;
         $display("FAIL random_op_count got=%0d exp=%0d", op_count, 20);
      end
      tests_run++;
      if (zero_count !== 16'(zero_results)) begin
         tests_failed++;
         $display("FAIL random_zero_count got=%0d exp=%0d", zero_count, zero_results);
      end
`endif
   endtask

   task automatic test_midstream_reset();
      in1 = 16'h0F0F;
      in2 = 16'h0000;
      tick();
      // reset edge with operands that would otherwise give 0xFFFF
      rst = 1'b1;
      in1 = 16'h0000;
      in2 = 16'h0000;
      tick();
      tests_run++;
      if ({out, out_valid, zero, all_ones, parity} !== {16'h0000, 4'b0000}) begin
         tests_failed++;
         $display("FAIL midreset got=%h/%b exp=%h/%b", out,
                  {out_valid, zero, all_ones, parity}, 16'h0000, 4'b0000);
      end
`ifdef NOR_GATE_STATS_EN
      tests_run++;
      if ({op_count, zero_count} !== 32'd0) begin
         tests_failed++;
         $display("FAIL midreset_counts got=%h/%h exp=0/0", op_count, zero_count);
      end
`endif
      rst = 1'b0;
      in1 = 16'h00F0;
      in2 = 16'h0F00;
      tick();
      tests_run++;
      if ({out, out_valid, all_ones} !== {16'hF00F, 2'b10}) begin
         tests_failed++;
         $display("FAIL post_reset got=%h/%b exp=%h/%b", out, {out_valid, all_ones}, 16'hF00F, 2'b10);
      end
`ifdef NOR_GATE_STATS_EN
      tests_run++;
      if (op_count !== 16'd1) begin
         tests_failed++;
         $display("FAIL post_reset_op_count got=%0d exp=%0d", op_count, 1);
      end
`endif
   endtask

`ifdef NOR_GATE_STATS_EN
   task automatic test_stats_wrap();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      in1 = 16'hFFFF;
      in2 = 16'h0000;
      repeat (3) tick();
      in1 = 16'h0000;
      for (int i = 3; i < 65536; i++) begin
         tick();
      end
      tests_run++;
      if ({op_count, zero_count} !== {16'h0000, 16'd3}) begin
         tests_failed++;
         $display("FAIL wrap got=%h/%0d exp=%h/%0d", op_count, zero_count, 16'h0000, 3);
      end
      tick();
      tests_run++;
      if (op_count !== 16'd1) begin
         tests_failed++;
         $display("FAIL wrap_plus1 got=%0d exp=%0d", op_count, 1);
      end
      rst = 1'b1;
      tick();
      tests_run++;
      if ({op_count, zero_count} !== 32'd0) begin
         tests_failed++;
         $display("FAIL wrap_reset got=%h/%h exp=0/0", op_count, zero_count);
      end
      rst = 1'b0;
   endtask
`endif

   initial begin
      tests_run    = 0;
      tests_failed = 0;
      rst = 1'b1;
      in1 = 16'h0000;
      in2 = 16'h0000;
      @(negedge clk);
      test_reset();
      test_all_zero_operands();
      test_patterns();
      test_hold();
      test_random();
      test_midstream_reset();
`ifdef NOR_GATE_STATS_EN
      test_stats_wrap();
`endif
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
